// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_if
// Brief    : Handshaked data-memory port between the load/store unit and memory.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_if;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        output i_mem_ack, i_mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : Load/store unit: lane steering, load extension, stall and timeout.
// Revision : 1.0  initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_req,
    input  wire logic        i_wren,
    input  wire logic [3:0]  i_bmask,
    input  wire logic        i_u,
    input  wire logic [31:0] i_addr,
    input  wire logic [31:0] i_st_data,
    output logic      [31:0] o_ld_data,
    output logic             o_stall,
    output logic             o_done,
    output logic             o_misalign,
    output logic             o_timeout,
    lsu_mem_if.master        mem
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] c_CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [31:0]     r_mem_addr;
    logic [3:0]      r_mem_be;
    logic [31:0]     r_mem_wdata;
    logic [3:0]      r_bmask;
    logic [1:0]      r_off;
    logic            r_u;
    logic [31:0]     r_ld_data;
    logic            r_done;
    logic            r_timeout;

    logic [1:0]      w_off;
    logic            w_misalign;
    logic            w_idle_req;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_rsh;
    logic [31:0]     w_fmt;

    assign w_off      = i_addr[1:0];
    assign w_idle_req = (r_state == S_IDLE) && i_req;
    assign w_be       = i_bmask << w_off;
    assign w_wdata    = i_st_data << {w_off, 3'b000};

    always_comb begin
        w_misalign = 1'b1;
        case (i_bmask)
            4'b0001: w_misalign = 1'b0;
            4'b0011: w_misalign = w_off[0];
            4'b1111: w_misalign = |w_off;
            default: w_misalign = 1'b1;
        endcase
    end

    // Align the addressed lane to bit 0, then extend to the access size.
    assign w_rsh = mem.i_mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_fmt = w_rsh;
        case (r_bmask)
            4'b0001: w_fmt = {{24{~r_u & w_rsh[7]}},  w_rsh[7:0]};
            4'b0011: w_fmt = {{16{~r_u & w_rsh[15]}}, w_rsh[15:0]};
            default: w_fmt = w_rsh;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_bmask     <= '0;
            r_off       <= '0;
            r_u         <= 1'b0;
            r_ld_data   <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        if (w_misalign) begin
                            if (!i_wren) begin
                                r_ld_data <= '0;
                            end
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= i_wren;
                            r_mem_addr  <= {i_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_bmask     <= i_bmask;
                            r_off       <= w_off;
                            r_u         <= i_u;
                            r_cnt       <= '0;
                            r_state     <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack takes priority over an expiring counter.
                    if (mem.i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_RESP;
                        if (!r_mem_we) begin
                            r_ld_data <= w_fmt;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_mem_req <= 1'b0;
                        r_ld_data <= '0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A rejected load retires this cycle, so its zero result bypasses the register.
    assign o_ld_data  = (w_idle_req && w_misalign && !i_wren) ? 32'd0 : r_ld_data;
    assign o_misalign = w_idle_req && w_misalign;
    assign o_stall    = (w_idle_req && !w_misalign) || (r_state == S_ACCESS);
    assign o_done     = r_done;
    assign o_timeout  = r_timeout;

    assign mem.o_mem_req   = r_mem_req;
    assign mem.o_mem_we    = r_mem_we;
    assign mem.o_mem_addr  = r_mem_addr;
    assign mem.o_mem_be    = r_mem_be;
    assign mem.o_mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
